// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg : shared types and constants for the RV32M multiply/divide unit
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

  localparam int MD_XLEN = 32;
  localparam int CNT_W   = $clog2(MD_XLEN);

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIN  = 2'd3
  } md_state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit : iterative RV32M multiply (shift-add) / divide (restoring) unit
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_e          state;
  md_op_e             op_q;
  logic [XLEN-1:0]    a_q, b_q, addend;
  logic [2*XLEN-1:0]  acc;
  logic [CNT_W-1:0]   count;
  logic               neg_q, neg_r;

  logic               is_div, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]    mag_a, mag_b, special_res, fin_res;
  logic [XLEN:0]      mul_sum, rem_sh;
  logic               no_borrow;
  logic [2*XLEN-1:0]  mul_next, div_next, acc_step, prod_s;

  assign is_div   = op_q[2];
  assign a_neg    = a_q[XLEN-1] && (op_q inside {MULH, MULHSU, DIV, REM});
  assign b_neg    = b_q[XLEN-1] && (op_q inside {MULH, DIV, REM});
  assign mag_a    = a_neg ? -a_q : a_q;
  assign mag_b    = b_neg ? -b_q : b_q;
  assign div_zero = is_div && (b_q == '0);
  assign div_ovf  = (op_q == DIV || op_q == REM) &&
                    (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);

  // op_q[1] distinguishes remainder from quotient within the divide group
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = op_q[1] ? a_q : '1;
    else if (div_ovf)
      special_res = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // Multiply: {hi, lo} with multiplier in lo; the XLEN+1-bit sum keeps the carry.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, addend} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Divide: {rem, quo}; the XLEN+1-bit window holds the shifted partial remainder.
  assign rem_sh    = acc[2*XLEN-1:XLEN-1];
  assign no_borrow = rem_sh >= {1'b0, addend};
  assign div_next  = no_borrow ? {XLEN'(rem_sh - {1'b0, addend}), acc[XLEN-2:0], 1'b1}
                               : {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};

  assign acc_step = is_div ? div_next : mul_next;
  assign prod_s   = neg_q ? -acc_step : acc_step;

  always_comb begin
    fin_res = '0;
    case (op_q)
      MUL:                 fin_res = prod_s[XLEN-1:0];
      MULH, MULHSU, MULHU: fin_res = prod_s[2*XLEN-1:XLEN];
      DIV, DIVU:           fin_res = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      REM, REMU:           fin_res = neg_r ? -acc_step[2*XLEN-1:XLEN]
                                           : acc_step[2*XLEN-1:XLEN];
      default:             fin_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      count  <= '0;
      op_q   <= MUL;
      a_q    <= '0;
      b_q    <= '0;
      addend <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            op_q  <= md_op_e'(op);
            a_q   <= A;
            b_q   <= B;
            busy  <= 1'b1;
            state <= PREP;
          end
          PREP: begin
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            count  <= '0;
            addend <= is_div ? mag_b : mag_a;
            acc    <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            if (div_zero || div_ovf) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= FIN;
            end else begin
              state <= CALC;
            end
          end
          CALC: begin
            acc   <= acc_step;
            count <= count + 1'b1;
            // Final step registers the corrected result so done lines up with FIN
            if (count == CNT_W'(XLEN-1)) begin
              result <= fin_res;
              done   <= 1'b1;
              state  <= FIN;
            end
          end
          FIN: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit : directed self-checking bench for muldiv_unit
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] A = '0;
  logic [XLEN-1:0] B = '0;
  logic            busy, done;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller is just after a negedge with the DUT idle; that cycle is cycle 0.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string tag);
    int n;
    bit busy_ok;
    op = o; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
    n = 1; busy_ok = 1'b1;
    while (!done && n < 60) begin
      busy_ok &= busy;
      @(negedge clk);
      n++;
    end
    busy_ok &= busy;
    check({tag, " latency"}, n, lat);
    check({tag, " result"}, result, exp);
    check({tag, " busy"}, busy_ok, 1);
    @(negedge clk);
    check({tag, " idle"}, {busy, done}, 2'b00);
  endtask

  logic [31:0] ta [3] = '{32'd3, 32'h0001_0000, 32'hFFFF_FFFE};
  logic [31:0] tb [3] = '{32'd5, 32'h0001_0000, 32'hFFFF_FFFD};
  logic [31:0] te [3] = '{32'd15, 32'd0, 32'd6};

  initial begin
    int n, k;
    int dc [3];
    bit seen;

    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul 7x-3");
    run_op(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh");
    run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");
    run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
    run_op(DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div -7/2");
    run_op(REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "rem -7%2");
    run_op(DIVU,   32'd100,       32'd7,         32'd14,        34, "divu 100/7");
    run_op(REMU,   32'd100,       32'd7,         32'd2,         34, "remu 100%7");

    // Flush at cycle 10 of a DIVU; result must stay at the previous value (2)
    op = DIVU; A = 32'd1000; B = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1; seen = 1'b0;
    while (n < 10) begin
      seen |= done;
      @(negedge clk);
      n++;
    end
    check("flush busy before", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen |= done;
    check("flush busy after", busy, 0);
    check("flush no done", seen, 0);
    check("flush result held", result, 32'd2);
    run_op(DIVU, 32'd100, 32'd7, 32'd14, 34, "divu after flush");

    // Asynchronous reset during CALC clears outputs immediately
    op = MUL; A = 32'd9; B = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("mid busy", busy, 1);
    rst = 1'b1;
    #1;
    check("async rst busy", busy, 0);
    check("async rst done", done, 0);
    check("async rst result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(DIV,  32'd5,        32'd0,         32'hFFFF_FFFF, 2, "div by zero");
    run_op(REM,  32'd5,        32'd0,         32'd5,         2, "rem by zero");
    run_op(DIVU, 32'd5,        32'd0,         32'hFFFF_FFFF, 2, "divu by zero");
    run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div overflow");
    run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2, "rem overflow");

    // start held high: one op per 35 cycles, operands scrambled while busy
    k = 0;
    dc = '{0, 0, 0};
    for (int c = 0; c < 110; c++) begin
      if (done) begin
        if (k < 3) begin
          dc[k] = c;
          check("held start result", result, te[k]);
        end
        k++;
      end
      if (c >= 105) begin
        start = 1'b0;
      end else begin
        start = 1'b1;
        op = MUL;
        if (busy || k >= 3) begin
          A = $urandom; B = $urandom;
        end else begin
          A = ta[k]; B = tb[k];
        end
      end
      @(negedge clk);
    end
    check("held start op count", k, 3);
    check("held start done 0", dc[0], 34);
    check("held start done 1", dc[1], 69);
    check("held start done 2", dc[2], 104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
